// File: rtl/planet_capture_scan_pkg.sv
// planet_pkg: planet table, scan geometry and scan FSM state type for planet_capture_scan
package planet_pkg;
  localparam int NUM_PLANETS = 8;
  localparam int COORD_W = 10;
  localparam int SIZE_W = 6;
  localparam int IDX_W = $clog2(NUM_PLANETS);
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SIZE_W-1:0] size_t;
  typedef logic [IDX_W-1:0] idx_t;
  localparam coord_t PLANET_X [NUM_PLANETS] = '{10'd350, 10'd100, 10'd420, 10'd500, 10'd580, 10'd540, 10'd180, 10'd100};
  localparam coord_t PLANET_Y [NUM_PLANETS] = '{10'd250, 10'd100, 10'd50, 10'd340, 10'd380, 10'd110, 10'd200, 10'd400};
  localparam size_t PLANET_S [NUM_PLANETS] = '{6'd10, 6'd20, 6'd12, 6'd19, 6'd8, 6'd24, 6'd18, 6'd10};
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
endpackage

// File: rtl/planet_capture_scan_capture_check.sv
// capture_check: combinational test of vessel/planet overlap, dx^2+dy^2 <= (vs+ps)^2
module capture_check
  import planet_pkg::*;
(
  input  logic [COORD_W-1:0] vx_i,
  input  logic [COORD_W-1:0] vy_i,
  input  logic [SIZE_W-1:0]  vs_i,
  input  logic [COORD_W-1:0] px_i,
  input  logic [COORD_W-1:0] py_i,
  input  logic [SIZE_W-1:0]  ps_i,
  output logic               hit_o
);
  logic signed [COORD_W:0] dx, dy;
  logic signed [2*COORD_W+2:0] dxe, dye;
  logic [2*COORD_W+2:0] dsq;
  logic [SIZE_W:0] r;
  logic [2*SIZE_W+1:0] rsq;
  assign dx = $signed({1'b0, vx_i}) - $signed({1'b0, px_i});
  assign dy = $signed({1'b0, vy_i}) - $signed({1'b0, py_i});
  assign dxe = {{(COORD_W+2){dx[COORD_W]}}, dx};
  assign dye = {{(COORD_W+2){dy[COORD_W]}}, dy};
  assign dsq = $unsigned(dxe * dxe + dye * dye);
  assign r = {1'b0, vs_i} + {1'b0, ps_i};
  assign rsq = {{(SIZE_W+1){1'b0}}, r} * {{(SIZE_W+1){1'b0}}, r};
  assign hit_o = dsq <= {{(2*COORD_W-2*SIZE_W+1){1'b0}}, rsq};
endmodule

// File: rtl/planet_capture_scan.sv
// planet_capture_scan: per-frame scan of all planets through one shared capture_check.
// Define PLANET_SCAN_EARLY_EXIT_EN to end the scan at the first capturing planet.
module planet_capture_scan
  import planet_pkg::*;
(
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [COORD_W-1:0] vessel_x,
  input  logic [COORD_W-1:0] vessel_y,
  input  logic [SIZE_W-1:0]  vessel_s,
  input  logic               skip_en,
  input  logic [IDX_W-1:0]   skip_idx,
  output logic               busy,
  output logic               done,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_idx
);
  scan_state_t state_q;
  coord_t vx_q, vy_q;
  size_t vs_q;
  logic sen_q, found_q, hit_q, chk_hit, hit_now, last;
  idx_t sidx_q, idx_q, found_idx_q, hit_idx_q;
  capture_check u_chk (
    .vx_i (vx_q),
    .vy_i (vy_q),
    .vs_i (vs_q),
    .px_i (PLANET_X[idx_q]),
    .py_i (PLANET_Y[idx_q]),
    .ps_i (PLANET_S[idx_q]),
    .hit_o(chk_hit)
  );
  assign hit_now = chk_hit && !(sen_q && idx_q == sidx_q);
`ifdef PLANET_SCAN_EARLY_EXIT_EN
  assign last = idx_q == idx_t'(NUM_PLANETS-1) || hit_now;
`else
  assign last = idx_q == idx_t'(NUM_PLANETS-1);
`endif
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= IDLE;
      vx_q <= '0;
      vy_q <= '0;
      vs_q <= '0;
      sen_q <= 1'b0;
      sidx_q <= '0;
      idx_q <= '0;
      found_q <= 1'b0;
      found_idx_q <= '0;
      hit_q <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= SCAN;
          vx_q <= vessel_x;
          vy_q <= vessel_y;
          vs_q <= vessel_s;
          sen_q <= skip_en;
          sidx_q <= skip_idx;
          idx_q <= '0;
          found_q <= 1'b0;
          found_idx_q <= '0;
        end
        SCAN: begin
          if (hit_now && !found_q) begin
            found_q <= 1'b1;
            found_idx_q <= idx_q;
          end
          idx_q <= idx_q + 1'b1;
          if (last) begin
            state_q <= DONE;
            hit_q <= found_q || hit_now;
            hit_idx_q <= found_q ? found_idx_q : hit_now ? idx_q : '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign hit = hit_q;
  assign hit_idx = hit_idx_q;
endmodule

// File: tb/tb_planet_capture_scan.sv
// tb_planet_capture_scan: directed vectors with a scoreboard queue checked by a done monitor
module tb_planet_capture_scan;
  logic frame_clk = 1'b0, Reset = 1'b1, start = 1'b0;
  logic [9:0] vessel_x = '0, vessel_y = '0;
  logic [5:0] vessel_s = '0;
  logic skip_en = 1'b0;
  logic [2:0] skip_idx = '0;
  logic busy, done, hit;
  logic [2:0] hit_idx;
  typedef struct {logic h; logic [2:0] i; int lat; int scyc;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0;
  int cx [8] = '{350, 100, 420, 500, 580, 540, 180, 100};
  int cy [8] = '{250, 100, 50, 340, 380, 110, 200, 400};

  planet_capture_scan dut (
    .frame_clk(frame_clk), .Reset(Reset), .start(start),
    .vessel_x(vessel_x), .vessel_y(vessel_y), .vessel_s(vessel_s),
    .skip_en(skip_en), .skip_idx(skip_idx),
    .busy(busy), .done(done), .hit(hit), .hit_idx(hit_idx)
  );

  always #5 frame_clk = ~frame_clk;
  always @(posedge frame_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edges from the start-sampling edge to the edge entering DONE.
  function automatic int lat(input logic h, input int i);
`ifdef PLANET_SCAN_EARLY_EXIT_EN
    return h ? i + 1 : 8;
`else
    return 8;
`endif
  endfunction

  always @(posedge frame_clk) begin
    #1;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        check("hit", int'(hit), int'(e.h));
        check("hit_idx", int'(hit_idx), int'(e.i));
        check("latency", cyc - e.scyc, e.lat);
      end
    end
  end

  task automatic issue(input int x, input int y, input int s, input logic sen, input int sidx,
                       input logic eh, input int ei);
    @(negedge frame_clk);
    vessel_x = 10'(x);
    vessel_y = 10'(y);
    vessel_s = 6'(s);
    skip_en = sen;
    skip_idx = 3'(sidx);
    start = 1'b1;
    q.push_back('{eh, 3'(ei), lat(eh, ei), cyc + 1});
    @(negedge frame_clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge frame_clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected %0d pending", q.size());
      q.delete();
    end
  endtask

  task automatic scan(input int x, input int y, input int s, input logic sen, input int sidx,
                      input logic eh, input int ei);
    issue(x, y, s, sen, sidx, eh, ei);
    drain();
  endtask

  initial begin
    repeat (3) @(negedge frame_clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_hit_idx", int'(hit_idx), 0);
    Reset = 1'b0;
    scan(350, 250, 10, 0, 0, 1, 0);
    scan(30, 30, 10, 0, 0, 0, 0);
    scan(100, 400, 10, 0, 0, 1, 7);
    for (int i = 0; i < 8; i++) scan(cx[i], cy[i], 10, 0, 0, 1, i);
    scan(370, 250, 10, 0, 0, 1, 0);
    scan(371, 250, 10, 0, 0, 0, 0);
    scan(140, 150, 63, 0, 0, 1, 1);
    scan(140, 150, 63, 1, 1, 1, 6);
    // second start and new vessel inputs mid-scan must not disturb the running scan
    issue(140, 150, 63, 0, 0, 1, 1);
    repeat (2) @(negedge frame_clk);
    vessel_x = 10'd350;
    vessel_y = 10'd250;
    skip_en = 1'b1;
    skip_idx = 3'd1;
    start = 1'b1;
    @(negedge frame_clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge frame_clk);
    check("busy_after_midscan_start", int'(busy), 0);
    // start coinciding with done is dropped
    q.push_back('{1'b0, 3'd0, lat(1'b0, 0), cyc + 1});
    vessel_x = 10'd30;
    vessel_y = 10'd30;
    vessel_s = 6'd10;
    skip_en = 1'b0;
    start = 1'b1;
    @(negedge frame_clk);
    start = 1'b0;
    for (int n = 0; n < 30 && done !== 1'b1; n++) @(negedge frame_clk);
    vessel_x = 10'd100;
    vessel_y = 10'd400;
    start = 1'b1;
    @(negedge frame_clk);
    start = 1'b0;
    check("busy_after_done_start", int'(busy), 0);
    repeat (12) @(negedge frame_clk);
    check("hit_held", int'(hit), 0);
    scan(100, 400, 10, 0, 0, 1, 7);
    // reset during scan cycle 4 aborts without a done
    @(negedge frame_clk);
    vessel_x = 10'd30;
    vessel_y = 10'd30;
    start = 1'b1;
    @(negedge frame_clk);
    start = 1'b0;
    repeat (3) @(negedge frame_clk);
    check("busy_mid_scan", int'(busy), 1);
    Reset = 1'b1;
    @(negedge frame_clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_hit", int'(hit), 0);
    check("abort_hit_idx", int'(hit_idx), 0);
    Reset = 1'b0;
    repeat (12) @(negedge frame_clk);
    scan(580, 380, 10, 0, 0, 1, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
